// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

  // Arbiter phases: waiting for a request, waiting on memory, acking.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Owner encoding for the transaction in flight.
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // Data and address width of both ports and the memory side.
  localparam int WORD_W = 32;

  // Read data returned for write acks and for timed-out accesses.
  localparam logic [WORD_W-1:0] RDATA_FORCED = '0;

endpackage

// File: rtl/mem_arb_timer.sv
// Timeout counter for the arbiter's BUSY phase. The count is reloaded with
// zero whenever clr_i is high and advances while en_i is high; expire_o
// flags the last allowed cycle so the arbiter can force completion.
module mem_arb_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload to zero on clear, otherwise count enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High only during the final permitted BUSY cycle; the arbiter leaves
  // BUSY on that edge, so this never stays high for more than one cycle.
  assign expire_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and the
// data-memory stage (MEM). MEM has priority, but after STARVE_LIM
// consecutive MEM grants taken while IF was waiting, IF is served next.
// Each access is IDLE -> BUSY (issue + wait) -> RESP (one-cycle ack).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [WORD_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [WORD_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [WORD_W-1:0] dm_addr_i,
  input  logic [WORD_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [WORD_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_o,
  output logic              err_o
);

  // Streak counter is 4 bits because STARVE_LIM is limited to 1..15.
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  arb_state_t        state_q;
  logic              owner_q;
  logic [3:0]        streak_q;
  logic [3:0]        streak_d;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [WORD_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic [WORD_W-1:0] if_rdata_q;
  logic              dm_ack_q;
  logic [WORD_W-1:0] dm_rdata_q;
  logic              err_q;

  logic              dm_grant;
  logic              if_grant;
  logic              tmo_expire;
  logic              in_busy;
  logic [WORD_W-1:0] resp_data;

  assign in_busy = (state_q == BUSY);

  // BUSY-phase timeout counter; held at zero outside BUSY so every access
  // starts counting from its first BUSY cycle.
  mem_arb_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (~in_busy),
    .en_i     (in_busy),
    .expire_o (tmo_expire)
  );

  // Grant decision and streak update, meaningful only while IDLE: MEM wins
  // unless IF has already waited through STARVE_LIM MEM grants.
  always_comb begin
    dm_grant = dm_req_i & ~(if_req_i & (streak_q == LIM));
    if_grant = if_req_i & ~dm_grant;
    streak_d = streak_q;
    if (dm_grant) begin
      if (if_req_i) begin
        streak_d = (streak_q >= LIM) ? LIM : streak_q + 4'd1;
      end else begin
        streak_d = '0;
      end
    end else if (if_grant) begin
      streak_d = '0;
    end
  end

  // Data returned with the ack: writes and timeouts return the fixed value.
  always_comb begin
    resp_data = RDATA_FORCED;
    if (mem_ready_i && !mem_we_q) begin
      resp_data = mem_rdata_i;
    end
  end

  // Arbiter FSM with all port-facing outputs registered; the ack and its
  // data are raised on entry to RESP and dropped on the way back to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_ack_q    <= 1'b0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_ack_q   <= 1'b0;
      dm_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (dm_grant || if_grant) begin
            state_q     <= BUSY;
            mem_en_q    <= 1'b1;
            streak_q    <= streak_d;
            owner_q     <= dm_grant ? OWNER_DM : OWNER_IF;
            mem_we_q    <= dm_grant & dm_we_i;
            mem_addr_q  <= dm_grant ? dm_addr_i : if_addr_i;
            mem_wdata_q <= dm_grant ? dm_wdata_i : '0;
          end
        end
        BUSY: begin
          if (mem_ready_i || tmo_expire) begin
            state_q <= RESP;
            if (!mem_ready_i) begin
              err_q <= 1'b1;
            end
            if (owner_q == OWNER_DM) begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= resp_data;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= resp_data;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;

  // The pipeline holds while any request is still waiting for its ack.
  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single accesses,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int LIM = 4;
  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        stall_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .STARVE_LIM  (LIM),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_ack_o    (dm_ack_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Memory responder: answers each issue after mem_wait cycles.
  int          mem_wait = 0;
  int          mem_cnt = 0;
  bit          mem_active = 1'b0;
  bit          mem_auto = 1'b1;
  logic [31:0] mem_data = '0;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_cyc;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; inputs for the new cycle may be driven on return,
  // outputs are sampled one time unit later.
  task automatic cycle();
    @(posedge clk_i);
    #1;
    cyc++;
    if (mem_auto) begin
      if (mem_en_o) begin
        mem_active = 1'b1;
        mem_cnt    = mem_wait;
      end
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'hBAD0_0000 ^ 32'(cyc);
      if (mem_active) begin
        if (mem_cnt == 0) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem_data;
          mem_active  = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    if_req_i   = 1'b0;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    if_addr_i  = '0;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    mem_active = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_if_ack"}, 32'(if_ack_o), 32'd0);
    check({tag, "_dm_ack"}, 32'(dm_ack_o), 32'd0);
    check({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    check({tag, "_dm_rdata"}, dm_rdata_o, 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en_o), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  // One isolated access from IDLE: request in cycle 0, ack expected in
  // cycle exp_lat, then one IDLE cycle.
  task automatic run_txn(input vec_t v, input int idx);
    int lat;
    int en_cnt;
    bit got;
    mem_wait   = v.wait_cyc;
    mem_data   = v.rdata;
    if_req_i   = v.is_if;
    dm_req_i   = !v.is_if;
    dm_we_i    = v.we;
    if_addr_i  = v.addr;
    dm_addr_i  = v.addr;
    dm_wdata_i = v.wdata;
    #1;
    check("txn_stall_c0", 32'(stall_o), 32'd1);
    lat = 0;
    en_cnt = 0;
    got = 1'b0;
    for (int k = 1; k <= TMO + 4 && !got; k++) begin
      cycle();
      // Scramble the request fields after the grant edge: the latched copies must win.
      if_addr_i  = ~v.addr;
      dm_addr_i  = ~v.addr;
      dm_wdata_i = ~v.wdata;
      dm_we_i    = v.is_if ? 1'b0 : !v.we;
      #1;
      if (mem_en_o) begin
        en_cnt++;
        check("issue_addr", mem_addr_o, v.addr);
        check("issue_we", 32'(mem_we_o), 32'(v.we));
        if (v.we) check("issue_wdata", mem_wdata_o, v.wdata);
      end
      if (if_ack_o || dm_ack_o) begin
        got = 1'b1;
        lat = k;
        check("ack_if", 32'(if_ack_o), 32'(v.is_if));
        check("ack_dm", 32'(dm_ack_o), 32'(!v.is_if));
        check("ack_rdata", v.is_if ? if_rdata_o : dm_rdata_o, v.exp_rdata);
        check("ack_other_rdata", v.is_if ? dm_rdata_o : if_rdata_o, 32'd0);
        check("held_addr", mem_addr_o, v.addr);
        check("held_we", 32'(mem_we_o), 32'(v.we));
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
      end else begin
        check("busy_stall", 32'(stall_o), 32'd1);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL txn%0d_no_ack: got no ack, required one within %0d cycles", idx, TMO + 4);
    end else begin
      check("latency", 32'(lat), 32'(v.exp_lat));
    end
    check("issue_count", 32'(en_cnt), 32'd1);
    cycle();
    #1;
    check("post_if_ack", 32'(if_ack_o), 32'd0);
    check("post_dm_ack", 32'(dm_ack_o), 32'd0);
    check("post_rdata", if_rdata_o | dm_rdata_o, 32'd0);
    check("post_stall", 32'(stall_o), 32'd0);
    $display("txn %0d: %s addr=%h we=%0d latency=%0d", idx, v.is_if ? "IF" : "DM", v.addr, v.we, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_en_k, if_en_k, dm_ack_k, if_ack_k, en_k, ack_k, ngr;
    logic [31:0] first_addr, if_addr_seen, if_rd;
    int got_order[6];
    int exp_order[6];
    // Random-phase model state
    int m_free, exp_issue, ack_cyc, streak, w;
    bit m_own_dm, m_we, tmo_txn, err_exp, e_if, e_dm;
    logic [31:0] m_addr, m_wdata, m_data;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h8C01_0004, 0, 32'h8C01_0004, 2};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0010, 32'h5, 32'hFFFF_FFFF, 3, 32'h0, 5};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 3};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5, 2};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h7777_7777, 0, 32'h0, 2};

    // Reset state
    do_reset();
    #1;
    check_zero_outputs("reset");
    check("reset_stall", 32'(stall_o), 32'd0);

    // Table of isolated accesses
    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Simultaneous requests, memory answers 3 cycles after issue
    mem_wait  = 3;
    mem_data  = 32'h1111_2222;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0400;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h0000_0500;
    first_en_k = -1; if_en_k = -1; dm_ack_k = -1; if_ack_k = -1;
    first_addr = '0; if_addr_seen = '0; if_rd = '0;
    for (int k = 1; k <= 30 && if_ack_k < 0; k++) begin
      cycle();
      #1;
      if (mem_en_o) begin
        if (first_en_k < 0) begin
          first_en_k = k;
          first_addr = mem_addr_o;
        end else if (if_en_k < 0) begin
          if_en_k = k;
          if_addr_seen = mem_addr_o;
        end
      end
      if (dm_ack_o && dm_ack_k < 0) begin
        dm_ack_k = k;
        dm_req_i = 1'b0;
        mem_data = 32'h3333_4444;
      end
      if (if_ack_o) begin
        if_ack_k = k;
        if_rd = if_rdata_o;
        if_req_i = 1'b0;
      end
    end
    check("simul_first_issue_cycle", 32'(first_en_k), 32'd1);
    check("simul_first_issue_addr", first_addr, 32'h0000_0500);
    check("simul_dm_ack_cycle", 32'(dm_ack_k), 32'd5);
    check("simul_if_issue_cycle", 32'(if_en_k), 32'd7);
    check("simul_if_issue_addr", if_addr_seen, 32'h0000_0400);
    check("simul_if_ack_cycle", 32'(if_ack_k), 32'd11);
    check("simul_if_rdata", if_rd, 32'h3333_4444);
    $display("txn simul: dm ack cycle %0d, if issue cycle %0d, if ack cycle %0d", dm_ack_k, if_en_k, if_ack_k);
    cycle();

    // Starvation bound with both requests held high
    do_reset();
    mem_wait  = 0;
    mem_data  = 32'h0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1000;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h0000_2000;
    exp_order = '{1, 1, 1, 1, 0, 1};
    got_order = '{-1, -1, -1, -1, -1, -1};
    ngr = 0;
    for (int k = 1; k <= 40 && ngr < 6; k++) begin
      cycle();
      #1;
      if (mem_en_o) begin
        got_order[ngr] = (mem_addr_o == 32'h0000_2000) ? 1 : 0;
        ngr++;
      end
    end
    check("starve_grant_count", 32'(ngr), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("starve_grant_%0d_is_dm", i), 32'(got_order[i]), 32'(exp_order[i]));
    $display("txn starve: grant order %0d %0d %0d %0d %0d %0d (1=MEM)",
             got_order[0], got_order[1], got_order[2], got_order[3], got_order[4], got_order[5]);
    if_req_i = 1'b0;
    dm_req_i = 1'b0;

    // Timeout on a MEM write with no ready
    do_reset();
    mem_auto    = 1'b0;
    mem_ready_i = 1'b0;
    dm_req_i    = 1'b1;
    dm_we_i     = 1'b1;
    dm_addr_i   = 32'h0000_0010;
    dm_wdata_i  = 32'h0000_0005;
    en_k = -1;
    ack_k = -1;
    for (int k = 1; k <= 20 && ack_k < 0; k++) begin
      cycle();
      mem_rdata_i = 32'hFFFF_FFFF;
      #1;
      if (mem_en_o && en_k < 0) begin
        en_k = k;
        check("tmo_err_at_issue", 32'(err_o), 32'd0);
      end
      if (dm_ack_o) begin
        ack_k = k;
        check("tmo_rdata", dm_rdata_o, 32'd0);
        check("tmo_err_at_ack", 32'(err_o), 32'd1);
        dm_req_i = 1'b0;
      end else if (en_k >= 0) begin
        check("tmo_hold_we", 32'(mem_we_o), 32'd1);
        check("tmo_hold_addr", mem_addr_o, 32'h0000_0010);
        check("tmo_hold_wdata", mem_wdata_o, 32'h0000_0005);
      end
    end
    if (ack_k < 0 || en_k < 0) begin
      checks++;
      failures++;
      $display("FAIL tmo_no_ack: got issue %0d ack %0d, required both", en_k, ack_k);
    end else begin
      check("tmo_busy_cycles", 32'(ack_k - en_k), 32'(TMO));
    end
    $display("txn timeout: issue cycle %0d ack cycle %0d", en_k, ack_k);
    repeat (5) cycle();
    #1;
    check("tmo_err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of BUSY, with a stale ready afterwards
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0600;
    cycle();
    #1;
    check("rstbusy_issue", 32'(mem_en_o), 32'd1);
    cycle();
    rst_i = 1'b1;
    cycle();
    rst_i    = 1'b0;
    if_req_i = 1'b0;
    #1;
    check_zero_outputs("rstbusy");
    cycle();
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hDEAD_0600;
    #1;
    check("rstbusy_ready_if_ack", 32'(if_ack_o), 32'd0);
    cycle();
    mem_ready_i = 1'b0;
    #1;
    check_zero_outputs("rstbusy_late");
    cycle();
    #1;
    check("rstbusy_late2_if_ack", 32'(if_ack_o), 32'd0);
    mem_auto = 1'b1;
    run_txn('{1'b1, 1'b0, 32'h0000_0700, 32'h0, 32'h0BAD_CAFE, 1, 32'h0BAD_CAFE, 3}, 99);

    // Randomized traffic against a transaction-level model
    do_reset();
    m_free = cyc;
    exp_issue = -1;
    ack_cyc = -1;
    streak = 0;
    err_exp = 1'b0;
    m_own_dm = 1'b0;
    m_we = 1'b0;
    tmo_txn = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_data = '0;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (cyc == ack_cyc) begin
        if (m_own_dm) dm_req_i = 1'b0;
        else if_req_i = 1'b0;
      end else begin
        if (!if_req_i && $urandom_range(0, 3) == 0) begin
          if_req_i  = 1'b1;
          if_addr_i = $urandom;
        end
        if (!dm_req_i && $urandom_range(0, 3) == 0) begin
          dm_req_i   = 1'b1;
          dm_we_i    = 1'($urandom_range(0, 1));
          dm_addr_i  = $urandom;
          dm_wdata_i = $urandom;
        end
      end
      #1;
      if (cyc == ack_cyc && tmo_txn) err_exp = 1'b1;
      e_if = (cyc == ack_cyc) && !m_own_dm;
      e_dm = (cyc == ack_cyc) && m_own_dm;
      check("rnd_mem_en", 32'(mem_en_o), 32'(cyc == exp_issue));
      if (cyc == exp_issue) begin
        check("rnd_issue_addr", mem_addr_o, m_addr);
        check("rnd_issue_we", 32'(mem_we_o), 32'(m_we));
        if (m_we) check("rnd_issue_wdata", mem_wdata_o, m_wdata);
      end
      check("rnd_if_ack", 32'(if_ack_o), 32'(e_if));
      check("rnd_dm_ack", 32'(dm_ack_o), 32'(e_dm));
      check("rnd_if_rdata", if_rdata_o, e_if ? m_data : 32'd0);
      check("rnd_dm_rdata", dm_rdata_o, e_dm ? m_data : 32'd0);
      check("rnd_stall", 32'(stall_o), 32'((if_req_i && !e_if) || (dm_req_i && !e_dm)));
      check("rnd_err", 32'(err_o), 32'(err_exp));
      if (cyc == ack_cyc) begin
        $display("txn rnd: %s addr=%h we=%0d timeout=%0d ack cycle %0d",
                 m_own_dm ? "DM" : "IF", m_addr, m_we, tmo_txn, cyc);
      end
      if (cyc >= m_free && (if_req_i || dm_req_i)) begin
        m_own_dm = dm_req_i && !(if_req_i && streak == LIM);
        if (m_own_dm) streak = if_req_i ? ((streak < LIM) ? streak + 1 : LIM) : 0;
        else streak = 0;
        m_addr  = m_own_dm ? dm_addr_i : if_addr_i;
        m_we    = m_own_dm && dm_we_i;
        m_wdata = dm_wdata_i;
        w = ($urandom_range(0, 11) == 0) ? 20 : int'($urandom_range(0, 4));
        tmo_txn  = (w >= TMO);
        mem_wait = w;
        mem_data = $urandom;
        m_data   = (m_we || tmo_txn) ? 32'd0 : mem_data;
        exp_issue = cyc + 1;
        ack_cyc   = cyc + 1 + ((w < TMO) ? w : TMO - 1) + 1;
        m_free    = ack_cyc + 1;
      end
    end
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
